// File: rtl/i2s_mic_array_rx.sv
// I2S master/receiver for the 4-mic array: generates SCK/WS and deserialises two
// stereo data lines into four signed samples with a once-per-frame valid pulse.
module i2s_mic_array_rx #(
  parameter int unsigned BITS_AUDIO     = 24,
  parameter int unsigned CLK_DIV        = 16,
  parameter int unsigned STARTUP_FRAMES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en_in,
  input  logic                  sd_a_in,
  input  logic                  sd_b_in,
  output logic                  sck_out,
  output logic                  ws_out,
  output logic [BITS_AUDIO-1:0] audio_out_1,
  output logic [BITS_AUDIO-1:0] audio_out_2,
  output logic [BITS_AUDIO-1:0] audio_out_3,
  output logic [BITS_AUDIO-1:0] audio_out_4,
  output logic                  valid_out
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned FR_W  = $clog2(STARTUP_FRAMES + 2);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                r_state;
  logic [DIV_W-1:0]      r_div;
  logic [5:0]            r_bit;
  logic [FR_W-1:0]       r_frames;
  logic [1:0]            r_sync_a;
  logic [1:0]            r_sync_b;
  logic [BITS_AUDIO-1:0] r_sh_1;
  logic [BITS_AUDIO-1:0] r_sh_2;
  logic [BITS_AUDIO-1:0] r_sh_3;
  logic [BITS_AUDIO-1:0] r_sh_4;

  logic w_half_end;
  logic w_bit_end;
  logic w_frame_end;
  logic w_data_bit;
  logic w_last_bit;
  logic w_post_startup;

  // Bit end = last clk of the SCK-high phase, which is also the capture point.
  assign w_half_end     = (r_state != IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_bit_end      = w_half_end && sck_out;
  assign w_frame_end    = w_bit_end && (r_bit == 6'd63);
  assign w_data_bit     = (r_bit[4:0] != 5'd0) && (r_bit[4:0] <= 5'(BITS_AUDIO));
  assign w_last_bit     = (r_bit == 6'(32 + BITS_AUDIO));
  assign w_post_startup = (r_frames == FR_W'(STARTUP_FRAMES));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_frames    <= '0;
      r_sync_a    <= '0;
      r_sync_b    <= '0;
      r_sh_1      <= '0;
      r_sh_2      <= '0;
      r_sh_3      <= '0;
      r_sh_4      <= '0;
      sck_out     <= 1'b0;
      ws_out      <= 1'b0;
      audio_out_1 <= '0;
      audio_out_2 <= '0;
      audio_out_3 <= '0;
      audio_out_4 <= '0;
      valid_out   <= 1'b0;
    end else begin
      r_sync_a  <= {r_sync_a[0], sd_a_in};
      r_sync_b  <= {r_sync_b[0], sd_b_in};
      valid_out <= 1'b0;
      case (r_state)
        IDLE: begin
          r_div   <= '0;
          r_bit   <= '0;
          sck_out <= 1'b0;
          ws_out  <= 1'b0;
          if (en_in) begin
            r_state  <= RUN;
            r_frames <= '0;
          end
        end
        default: begin
          r_div <= w_half_end ? '0 : r_div + DIV_W'(1);
          if (w_half_end) sck_out <= ~sck_out;
          if (w_bit_end) begin
            r_bit  <= r_bit + 6'd1;
            ws_out <= (r_bit + 6'd1) >= 6'd32;
            if (w_data_bit) begin
              if (!r_bit[5]) begin
                r_sh_1 <= {r_sh_1[BITS_AUDIO-2:0], r_sync_a[1]};
                r_sh_3 <= {r_sh_3[BITS_AUDIO-2:0], r_sync_b[1]};
              end else begin
                r_sh_2 <= {r_sh_2[BITS_AUDIO-2:0], r_sync_a[1]};
                r_sh_4 <= {r_sh_4[BITS_AUDIO-2:0], r_sync_b[1]};
              end
            end
            // Right-slot LSB completes the frame's sample set.
            if (w_last_bit) begin
              audio_out_1 <= r_sh_1;
              audio_out_2 <= {r_sh_2[BITS_AUDIO-2:0], r_sync_a[1]};
              audio_out_3 <= r_sh_3;
              audio_out_4 <= {r_sh_4[BITS_AUDIO-2:0], r_sync_b[1]};
              valid_out   <= w_post_startup;
            end
          end
          if (w_frame_end) begin
            if (!w_post_startup) r_frames <= r_frames + FR_W'(1);
            if (r_state == STOP || !en_in) r_state <= IDLE;
          end else if (r_state == RUN && !en_in) begin
            r_state <= STOP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Bench for i2s_mic_array_rx: behavioural I2S mic model, valid-event log and
// directed phases checked against frame-timing arithmetic.
module tb_i2s_mic_array_rx;

  localparam int BA    = 24;
  localparam int CD    = 16;
  localparam int FRAME = 128 * CD;
  localparam int VOFS  = (33 + BA) * 2 * CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sd_a = 1'b0;
  logic sd_b = 1'b0;
  logic sck_out, ws_out, valid_out;
  logic [BA-1:0] audio_out_1, audio_out_2, audio_out_3, audio_out_4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [BA-1:0] mic [4];
  bit            garbage = 1'b0;
  int            ev_c [$];
  logic [95:0]   ev_d [$];
  int            sck_rise [$];
  int            ws_rise [$];

  i2s_mic_array_rx #(.BITS_AUDIO(BA), .CLK_DIV(CD), .STARTUP_FRAMES(2)) dut (
    .clk_in(clk), .rst_in(rst_n), .en_in(en), .sd_a_in(sd_a), .sd_b_in(sd_b),
    .sck_out(sck_out), .ws_out(ws_out),
    .audio_out_1(audio_out_1), .audio_out_2(audio_out_2),
    .audio_out_3(audio_out_3), .audio_out_4(audio_out_4),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic slot_bit(logic [BA-1:0] w, int s);
    if (s >= 1 && s <= BA) return w[BA-s];
    return garbage ? 1'b1 : 1'($urandom);
  endfunction

  // Mic model: slot index restarts on a WS change or after the clock has been idle.
  int   s_idx = 0;
  int   m_low = 100;
  bit   m_idle = 1'b1;
  logic m_last_sck = 1'b0;
  logic m_last_ws = 1'b0;
  logic m_prev_ws = 1'b0;
  always @(negedge clk) begin
    if (valid_out) begin
      ev_c.push_back(cyc);
      ev_d.push_back({audio_out_1, audio_out_2, audio_out_3, audio_out_4});
    end
    if (sck_out && !m_last_sck) begin
      sck_rise.push_back(cyc);
      if (ws_out != m_last_ws || m_idle) s_idx = 0;
      else s_idx++;
      m_last_ws = ws_out;
      m_idle = 1'b0;
      sd_a = slot_bit(ws_out ? mic[1] : mic[0], s_idx);
      sd_b = slot_bit(ws_out ? mic[3] : mic[2], s_idx);
    end else if (m_idle) begin
      sd_a = 1'($urandom);
      sd_b = 1'($urandom);
    end
    if (ws_out && !m_prev_ws) ws_rise.push_back(cyc);
    m_low = sck_out ? 0 : m_low + 1;
    if (m_low > CD + 2) m_idle = 1'b1;
    m_last_sck = sck_out;
    m_prev_ws = ws_out;
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    ev_c.delete();
    ev_d.delete();
    sck_rise.delete();
    ws_rise.delete();
  endtask

  function automatic logic [95:0] exp_word();
    return {mic[0], mic[1], mic[2], mic[3]};
  endfunction

  function automatic logic [98:0] all_outs();
    return {sck_out, ws_out, valid_out, audio_out_1, audio_out_2, audio_out_3, audio_out_4};
  endfunction

  int t0, t1, t2, fs, flat_bad;

  initial begin
    for (int i = 0; i < 4; i++) mic[i] = '0;
    rst_n = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", 128'(all_outs()), 128'(0));
    end

    // Fixed data-path words, startup suppression and pulse timing.
    mic[0] = 24'h123456; mic[1] = 24'hFEDCBA; mic[2] = 24'h800000; mic[3] = 24'h7FFFFF;
    clear_logs();
    rst_n = 1'b1;
    t0 = cyc + 1;
    step_to(t0 + VOFS + 2);
    chk("suppressed_no_valid", 128'(ev_c.size()), 128'(0));
    chk("suppressed_update", 128'({audio_out_1, audio_out_2, audio_out_3, audio_out_4}), 128'(exp_word()));
    step_to(t0 + 5 * FRAME + 100);
    chk("valid_count", 128'(ev_c.size()), 128'(3));
    for (int i = 0; i < ev_c.size(); i++) begin
      chk("valid_time", 128'(ev_c[i]), 128'(t0 + VOFS + (i + 2) * FRAME));
      chk("valid_data", 128'(ev_d[i]), 128'(exp_word()));
    end
    chk("outputs_hold", 128'({audio_out_1, audio_out_2, audio_out_3, audio_out_4}), 128'(exp_word()));
    chk("sck_period", 128'(sck_rise[sck_rise.size()-1] - sck_rise[sck_rise.size()-2]), 128'(2 * CD));
    chk("ws_period", 128'(ws_rise[ws_rise.size()-1] - ws_rise[ws_rise.size()-2]), 128'(FRAME));
    chk("ws_first_rise", 128'(ws_rise[0]), 128'(t0 + 32 * 2 * CD));

    // Ones on the delay bit and the unused tail of each slot must be ignored.
    garbage = 1'b1;
    for (int i = 0; i < 4; i++) mic[i] = 24'h000001;
    clear_logs();
    step_to(cyc + 3 * FRAME);
    chk("garbage_count", 128'(ev_c.size()), 128'(3));
    chk("garbage_data", 128'(ev_d[ev_d.size()-1]), 128'({4{24'h000001}}));

    // Stop at b=10: current frame finishes with its pulse, then the bus goes quiet.
    fs = t0 + ((cyc - t0) / FRAME + 1) * FRAME;
    step_to(fs + 10 * 2 * CD);
    en = 1'b0;
    clear_logs();
    step_to(fs + FRAME + 10);
    flat_bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (sck_out || ws_out) flat_bad++;
    end
    chk("stop_flat", 128'(flat_bad), 128'(0));
    chk("stop_valid_count", 128'(ev_c.size()), 128'(1));
    if (ev_c.size() > 0) chk("stop_valid_time", 128'(ev_c[0]), 128'(fs + VOFS));

    // Re-enable with random words: startup suppression repeats.
    garbage = 1'b0;
    for (int i = 0; i < 4; i++) mic[i] = 24'($urandom);
    clear_logs();
    en = 1'b1;
    t1 = cyc + 1;
    step_to(t1 + 3 * FRAME + VOFS + 10);
    chk("reen_valid_count", 128'(ev_c.size()), 128'(2));
    if (ev_c.size() > 0) begin
      chk("reen_valid_time", 128'(ev_c[0]), 128'(t1 + 2 * FRAME + VOFS));
      chk("reen_valid_data", 128'(ev_d[0]), 128'(exp_word()));
    end

    // Reset at b=40: that frame yields nothing and timing restarts cleanly.
    fs = t1 + ((cyc - t1) / FRAME + 1) * FRAME;
    step_to(fs + 40 * 2 * CD);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mic[i] = 24'($urandom);
    clear_logs();
    @(posedge clk);
    #1;
    chk("midreset_outputs", 128'(all_outs()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t2 = cyc + 1;
    step_to(t2 + 2 * FRAME + VOFS + 10);
    chk("midreset_valid_count", 128'(ev_c.size()), 128'(1));
    if (ev_c.size() > 0) begin
      chk("midreset_valid_time", 128'(ev_c[0]), 128'(t2 + 2 * FRAME + VOFS));
      chk("midreset_valid_data", 128'(ev_d[0]), 128'(exp_word()));
    end
    chk("midreset_ws_rise", 128'(ws_rise[0]), 128'(t2 + 32 * 2 * CD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
